// File: rtl/sched_pkg.sv
// sched_pkg: shared defaults and FSM state encoding for the memory access scheduler.
package sched_pkg;
    localparam int DEF_NREQ = 4;
    localparam int DEF_AW   = 4;
    localparam int DEF_DW   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_i+1 with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    // Scanning farthest-first lets the nearest requester overwrite, so no found flag is needed.
    always_comb begin
        idx_o = '0;
        for (int k = NREQ; k > 0; k--)
            if (req_i[(int'(last_i) + k) % NREQ]) idx_o = IW'((int'(last_i) + k) % NREQ);
        gnt_o = (|req_i) ? NREQ'(1) << idx_o : '0;
    end
endmodule

// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler: round-robin scheduler giving NREQ requesters single-beat access
// to one memory port; the winner's command is latched at grant and immune to later input changes.
module mem_access_scheduler
    import sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q;
    logic [IW-1:0]   last_q, win_q, arb_idx;
    logic [NREQ-1:0] arb_gnt;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (req),
        .last_i(last_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign busy = (state_q != IDLE);

    // mem_we doubles as the latched direction until it is dropped on leaving ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= IW'(NREQ - 1);
            win_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    state_q   <= ISSUE;
                    gnt       <= arb_gnt;
                    win_q     <= arb_idx;
                    mem_en    <= 1'b1;
                    mem_we    <= we[arb_idx];
                    mem_addr  <= addr[arb_idx*AW +: AW];
                    mem_wdata <= wdata[arb_idx*DW +: DW];
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    state_q <= mem_we ? DONE : WAIT;
                    done    <= mem_we ? gnt : '0;
                end
                WAIT: begin
                    rdata   <= mem_rdata;
                    done    <= gnt;
                    state_q <= DONE;
                end
                default: begin
                    done    <= '0;
                    gnt     <= '0;
                    last_q  <= win_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb_mem_access_scheduler: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a transaction-level round-robin/memory model.
module tb_mem_access_scheduler;
    logic        clk, rst;
    logic [3:0]  req, we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [3:0]  gnt, done;
    logic [15:0] rdata;
    logic        busy, mem_en, mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] dmem [16];
    logic [15:0] ref_mem [16];
    int          checks = 0, failures = 0;
    int          last_m, w, len;
    logic        lw;
    logic [3:0]  la;
    logic [15:0] ld, exp_rd;

    typedef struct {
        int          lane;
        logic        we;
        logic [3:0]  a;
        logic [15:0] d;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t tbl [7];

    mem_access_scheduler #(.NREQ(4), .AW(4), .DW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fill(input logic [3:0] a);
        return 16'hC3A5 ^ {4{a}};
    endfunction

    // Memory device: read data valid only the cycle after a read strobe, junk otherwise.
    always @(posedge clk) begin
        mem_rdata <= 16'($urandom);
        if (!rst) for (int i = 0; i < 16; i++) dmem[i] <= fill(4'(i));
        else if (mem_en && mem_we) dmem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= dmem[mem_addr];
    end

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        #1;
        check("reset_now", {gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}, 64'h0);
        @(negedge clk);
        check("reset_held", {gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}, 64'h0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = fill(4'(i));
        last_m = 3;
        exp_rd = '0;
    endtask

    task automatic run_txn(input int lane, input logic wr, input logic [3:0] a,
                           input logic [15:0] d, input logic [15:0] erd);
        int n;
        req = '0;
        req[lane] = 1'b1;
        we[lane] = wr;
        addr[lane*4 +: 4] = a;
        wdata[lane*16 +: 16] = d;
        @(negedge clk);
        check("txn_issue", {gnt, busy, mem_en, mem_we, mem_addr, wr ? mem_wdata : 16'h0},
              {4'(1 << lane), 1'b1, 1'b1, wr, a, wr ? d : 16'h0});
        n = 1;
        while (done == 4'h0 && n < 5) begin
            @(negedge clk);
            n++;
            check("txn_hold", {mem_en, mem_we, gnt}, {1'b0, 1'b0, 4'(1 << lane)});
        end
        check("txn_len", 64'(n), wr ? 64'd2 : 64'd3);
        check("txn_done", {60'h0, done}, 64'(1 << lane));
        req = '0;
        if (wr) ref_mem[a] = d;
        @(negedge clk);
        check("txn_idle", {gnt, done, busy, rdata}, {4'h0, 4'h0, 1'b0, erd});
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        #2;
        do_reset();

        tbl[0] = '{2, 1'b1, 4'h5, 16'hA5A5, 16'h0000};
        tbl[1] = '{1, 1'b0, 4'h5, 16'h0000, 16'hA5A5};
        tbl[2] = '{3, 1'b1, 4'hF, 16'hFFFF, 16'hA5A5};
        tbl[3] = '{0, 1'b0, 4'hF, 16'h1234, 16'hFFFF};
        tbl[4] = '{3, 1'b1, 4'h0, 16'h0000, 16'hFFFF};
        tbl[5] = '{1, 1'b0, 4'h0, 16'h0000, 16'h0000};
        tbl[6] = '{2, 1'b0, 4'hC, 16'h0000, fill(4'hC)};
        for (int i = 0; i < 7; i++) run_txn(tbl[i].lane, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].exp_rd);

        // Command and req change while in ISSUE must not disturb the write to addr 3.
        we[0] = 1'b1; addr[3:0] = 4'h3; wdata[15:0] = 16'h1234; req = 4'b0001;
        @(negedge clk);
        check("stab_issue", {gnt, mem_en, mem_we, mem_addr, mem_wdata}, {4'b0001, 1'b1, 1'b1, 4'h3, 16'h1234});
        addr[3:0] = 4'h9; wdata[15:0] = 16'hFFFF; we[0] = 1'b0; req = 4'b0000;
        @(negedge clk);
        check("stab_done", {gnt, done, mem_en}, {4'b0001, 4'b0001, 1'b0});
        ref_mem[3] = 16'h1234;
        @(negedge clk);
        check("stab_idle", {gnt, done, busy}, 64'h0);
        run_txn(1, 1'b0, 4'h3, 16'h0, 16'h1234);
        run_txn(1, 1'b0, 4'h9, 16'h0, fill(4'h9));

        do_reset();
        we = 4'b1111; req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check("fair_gnt", {60'h0, gnt}, (c % 3 == 2) ? 64'h0 : 64'(1 << ((c / 3) % 4)));
        end
        req = '0;
        run_txn(3, 1'b1, 4'h6, 16'h6666, 16'h0000);
        we = 4'b1111; req = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("wrap_gnt", {60'h0, gnt}, (c % 3 == 2) ? 64'h0 : (c < 3 ? 64'h1 : 64'h8));
        end
        req = '0;

        do_reset();
        we[2] = 1'b0; addr[8 +: 4] = 4'h7; req = 4'b0100;
        @(negedge clk);
        check("mid_issue", {60'h0, gnt}, 64'h4);
        @(negedge clk);
        check("mid_wait", {busy, gnt, done}, {1'b1, 4'b0100, 4'b0000});
        do_reset();
        req = 4'b0110; we = 4'b0010; addr[4 +: 4] = 4'h2; wdata[16 +: 16] = 16'hBEEF;
        @(negedge clk);
        check("rst_rr", {60'h0, gnt}, 64'h2);
        req = '0;
        ref_mem[2] = 16'hBEEF;
        @(negedge clk);
        check("rst_txn_done", {60'h0, done}, 64'h2);
        @(negedge clk);
        check("rst_txn_idle", {gnt, done, busy, rdata}, 64'h0);
        run_txn(0, 1'b0, 4'h2, 16'h0, 16'hBEEF);

        do_reset();
        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    we[i] = 1'($urandom);
                    addr[i*4 +: 4] = 4'($urandom);
                    wdata[i*16 +: 16] = 16'($urandom);
                end
            if (req == 4'h0) begin
                @(negedge clk);
                check("rnd_quiet", {gnt, done, busy, mem_en}, 64'h0);
                continue;
            end
            w = rr_pick(req, last_m);
            lw = we[w];
            la = addr[w*4 +: 4];
            ld = wdata[w*16 +: 16];
            len = lw ? 2 : 3;
            @(negedge clk);
            check("rnd_issue", {gnt, busy, mem_en, mem_we, mem_addr, lw ? mem_wdata : 16'h0},
                  {4'(1 << w), 1'b1, 1'b1, lw, la, lw ? ld : 16'h0});
            we[w] = 1'($urandom);
            addr[w*4 +: 4] = 4'($urandom);
            wdata[w*16 +: 16] = 16'($urandom);
            for (int c = 1; c < len; c++) begin
                @(negedge clk);
                check("rnd_hold", {gnt, done, busy, mem_en, mem_we},
                      {4'(1 << w), (c == len - 1) ? 4'(1 << w) : 4'h0, 1'b1, 1'b0, 1'b0});
            end
            if (lw) ref_mem[la] = ld;
            else exp_rd = ref_mem[la];
            req[w] = 1'b0;
            last_m = w;
            @(negedge clk);
            check("rnd_after", {gnt, done, busy, rdata}, {4'h0, 4'h0, 1'b0, exp_rd});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_scheduler.md
MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; AW, default 4, memory address width; DW, default 16, data width.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 req  input  NREQ  per-requester access request, level, held until done.
REQ-005 we  input  NREQ  per-requester direction; 1 = write, 0 = read.
REQ-006 addr  input  NREQ*AW  packed per-requester address; lane i at [i*AW +: AW].
REQ-007 wdata  input  NREQ*DW  packed per-requester write data; lane i at [i*DW +: DW].
REQ-008 gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-009 done  output  NREQ  one-hot, one-cycle completion pulse to the granted lane.
REQ-010 rdata  output  DW  registered read data of the last completed read.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-013 mem_addr  output  AW; mem_wdata  output  DW  memory address and write data.
REQ-014 mem_rdata  input  DW  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-016 IDLE: if any req bit is high, the FSM SHALL select a winner, latch that lane's we/addr/wdata, set gnt, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at lane (last_winner+1) mod NREQ and wraps; last_winner resets to NREQ-1, so lane 0 has first priority.
REQ-018 ISSUE: mem_en SHALL be 1 for exactly one cycle, with mem_we, mem_addr and mem_wdata taken from the latched command. Next state SHALL be DONE for a write and WAIT for a read.
REQ-019 WAIT: rdata SHALL load mem_rdata on the clock edge that leaves WAIT; next state SHALL be DONE.
REQ-020 DONE: done[winner] SHALL be 1 for one cycle; gnt SHALL clear on exit; last_winner SHALL update; next state SHALL be IDLE.
REQ-021 Latency from grant to done SHALL be 2 cycles for a write and 3 cycles for a read. Back-to-back transactions SHALL have one IDLE cycle between them.
REQ-022 Changes to req, we, addr or wdata after the grant SHALL NOT affect the transaction in flight. Deasserting req mid-transaction SHALL NOT abort it.
REQ-023 Outside ISSUE, mem_en and mem_we SHALL be 0. rdata SHALL hold its value until the next read completes; writes SHALL NOT change rdata.
REQ-024 gnt and done SHALL never have more than one bit set. done SHALL never assert for a lane that is not granted.

Reset
REQ-025 While rst=0, the block SHALL go to IDLE asynchronously and set gnt=0, done=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and last_winner=NREQ-1.
REQ-026 A reset during ISSUE, WAIT or DONE SHALL abandon the transaction with no done pulse. Arbitration SHALL restart from lane 0 after rst is released.

Structure
REQ-027 A shared package sched_pkg SHALL hold NREQ, AW, DW defaults and the state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3).
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_winner; outputs one-hot grant and index), instantiated once.

Verification
REQ-029 Single write: lane 2 req, we=1, addr=5, wdata=16'hA5A5 -> mem_en/mem_we high one cycle with addr 5 and data A5A5; done[2] 2 cycles after gnt[2]; rdata unchanged.
REQ-030 Single read: after REQ-029, lane 1 reads addr 5 with the memory model returning A5A5 -> done[1] 3 cycles after gnt[1]; rdata=16'hA5A5.
REQ-031 Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0, with exactly one IDLE cycle between transactions.
REQ-032 Wrap: last winner 3, req=4'b1001 -> lane 0 granted next, then lane 3.
REQ-033 Stability: lane 0 granted for a write to addr 3; addr changed to 9 and req dropped during ISSUE -> memory write still goes to addr 3; done[0] still pulses.
REQ-034 Reset mid-read: rst=0 during WAIT -> all outputs zero immediately, no done pulse; after release, req=4'b0110 -> lane 1 granted first.
